// File: rtl/tx_lane_striper_pkg.sv
// Shared symbol constants, FSM state encoding and the active-width decode
// used by the transmit lane striper.
package tx_lane_striper_pkg;

  localparam logic [7:0] K_COM     = 8'hBC;
  localparam logic [7:0] K_SKP     = 8'h1C;
  localparam logic [7:0] K_PAD     = 8'hF7;
  localparam logic [7:0] IDLE_LANE = 8'h00;

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_COM  = 2'd1,
    S_SKP  = 2'd2
  } tx_state_e;

  // cfg_lanes 0..3 selects x1/x2/x4/x8; anything wider than the build clamps.
  function automatic logic [3:0] lane_width(input logic [1:0] cfg, input int unsigned num_lanes);
    logic [3:0] w;
    w = 4'd1 << cfg;
    if (32'(w) > num_lanes) begin
      w = 4'(num_lanes);
    end
    return w;
  endfunction

endpackage

// File: rtl/tx_lane_striper_if.sv
// Byte-stream input handshake plus row output bus of the lane striper.
// slave = the striper, master = the block feeding it / consuming rows.
interface tx_lane_striper_if #(
  parameter int NUM_LANES = 4
);
  logic                   enb;
  logic [1:0]             cfg_lanes;
  logic [7:0]             in_data;
  logic                   in_k;
  logic                   in_last;
  logic                   in_valid;
  logic                   in_ready;
  logic [8*NUM_LANES-1:0] tx_lanes;
  logic [NUM_LANES-1:0]   tx_lanes_k;
  logic                   tx_lanes_valid;

  modport master (
    output enb, cfg_lanes, in_data, in_k, in_last, in_valid,
    input  in_ready, tx_lanes, tx_lanes_k, tx_lanes_valid
  );

  modport slave (
    input  enb, cfg_lanes, in_data, in_k, in_last, in_valid,
    output in_ready, tx_lanes, tx_lanes_k, tx_lanes_valid
  );
endinterface

// File: rtl/tx_lane_striper_row_assembler.sv
// Row assembler: collects accepted bytes into per-lane slots, tracks the
// fill count and presents the completed (padded) row combinationally in the
// cycle its final byte is accepted, so the top can register it directly.
module tx_row_assembler
  import tx_lane_striper_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   accept_i,
  input  logic [7:0]             data_i,
  input  logic                   k_i,
  input  logic                   last_i,
  input  logic [3:0]             width_i,
  output logic [3:0]             fill_o,
  output logic                   row_done_o,
  output logic [8*NUM_LANES-1:0] row_data_o,
  output logic [NUM_LANES-1:0]   row_k_o
);

  logic [3:0] fill_q, fill_d;

  // The row closes when this byte fills the last active slot or ends the packet.
  assign row_done_o = accept_i && (last_i || ((fill_q + 4'd1) >= width_i));
  assign fill_o     = fill_q;

  // Next fill count: advance per accepted byte, wrap to zero at row end.
  always_comb begin
    fill_d = fill_q;
    if (accept_i) begin
      fill_d = row_done_o ? 4'd0 : fill_q + 4'd1;
    end
  end

  // Fill count register; reset drops any partially collected row.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 4'd0;
    end else if (enb) begin
      fill_q <= fill_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [3:0] LANE = 4'(gi);
    logic [7:0] slot_data_q;
    logic       slot_k_q;

    // Capture the byte destined for this slot; stale contents are masked by fill.
    always_ff @(posedge clk) begin
      if (enb && accept_i && (fill_q == LANE)) begin
        slot_data_q <= data_i;
        slot_k_q    <= k_i;
      end
    end

    // Earlier slots come from storage, the current slot bypasses the incoming
    // byte, remaining active slots pad, and lanes beyond the width idle.
    assign row_data_o[8*gi +: 8] = (LANE < fill_q)  ? slot_data_q :
                                   (LANE == fill_q) ? data_i      :
                                   (LANE < width_i) ? K_PAD       : IDLE_LANE;
    assign row_k_o[gi]           = (LANE < fill_q)  ? slot_k_q    :
                                   (LANE == fill_q) ? k_i         :
                                   (LANE < width_i);
  end

endmodule

// File: rtl/tx_lane_striper.sv
// Transmit lane striper top: active-width latch, SKP interval counter,
// data/COM/SKP state machine and registered row outputs.
// Build option: define TX_SKP_INSERT_EN to include periodic SKP ordered-set
// insertion; without it the striper only emits data rows.
module tx_lane_striper
  import tx_lane_striper_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int SKP_INTERVAL = 64,
  parameter int SKP_LEN      = 3
) (
  input  logic             clk,
  input  logic             rst,
  tx_lane_striper_if.slave bus
);

  // Out-of-range parameters leave this marker block in the elaborated hierarchy.
  if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4 || NUM_LANES == 8) ||
      SKP_INTERVAL < 2 || SKP_INTERVAL > 4095 || SKP_LEN < 1 || SKP_LEN > 4) begin : g_illegal_params
  end

  tx_state_e              state_q, state_d;
  logic [3:0]             width_q, width_eff;
  logic [3:0]             fill;
  logic                   row_done;
  logic [8*NUM_LANES-1:0] row_data;
  logic [NUM_LANES-1:0]   row_k;
  logic                   in_ready;
  logic                   accept;
  logic [8*NUM_LANES-1:0] lanes_q, lanes_d;
  logic [NUM_LANES-1:0]   lanes_k_q, lanes_k_d;
  logic                   valid_q, valid_d;

  // The width follows cfg_lanes only at a row boundary in data mode; a row
  // (or ordered set) in progress keeps the width it started with.
  assign width_eff = ((fill == 4'd0) && (state_q == S_DATA)) ?
                     lane_width(bus.cfg_lanes, NUM_LANES) : width_q;
  assign accept    = bus.in_valid && in_ready;

  // Active width latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q <= lane_width(bus.cfg_lanes, NUM_LANES);
    end else if (bus.enb) begin
      width_q <= width_eff;
    end
  end

  tx_row_assembler #(.NUM_LANES(NUM_LANES)) u_row (
    .clk        (clk),
    .rst        (rst),
    .enb        (bus.enb),
    .accept_i   (accept),
    .data_i     (bus.in_data),
    .k_i        (bus.in_k),
    .last_i     (bus.in_last),
    .width_i    (width_eff),
    .fill_o     (fill),
    .row_done_o (row_done),
    .row_data_o (row_data),
    .row_k_o    (row_k)
  );

`ifdef TX_SKP_INSERT_EN
  localparam logic [11:0] SKP_MAX  = 12'(SKP_INTERVAL);
  localparam logic [2:0]  SKP_LAST = 3'(SKP_LEN - 1);

  logic [11:0] skp_cnt_q, skp_cnt_d;
  logic [2:0]  skp_idx_q, skp_idx_d;
  logic        skp_due;

  // Interval counting and data/COM/SKP sequencing. The due test uses the
  // post-increment count, so the ordered set starts right after the row that
  // reached the interval with no bubble on the lanes.
  always_comb begin
    state_d   = state_q;
    skp_cnt_d = skp_cnt_q;
    skp_idx_d = skp_idx_q;
    skp_due   = (state_q == S_DATA) && (skp_cnt_q == SKP_MAX) && (fill == 4'd0);
    unique case (state_q)
      S_DATA: begin
        if (row_done && (skp_cnt_q != SKP_MAX)) begin
          skp_cnt_d = skp_cnt_q + 12'd1;
        end
        if (skp_due || (row_done && (skp_cnt_d == SKP_MAX))) begin
          state_d = S_COM;
        end
      end
      S_COM: begin
        state_d   = S_SKP;
        skp_idx_d = 3'd0;
      end
      S_SKP: begin
        if (skp_idx_q == SKP_LAST) begin
          state_d   = S_DATA;
          skp_cnt_d = 12'd0;
        end else begin
          skp_idx_d = skp_idx_q + 3'd1;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  // SKP counter and ordered-set position.
  always_ff @(posedge clk) begin
    if (rst) begin
      skp_cnt_q <= 12'd0;
      skp_idx_q <= 3'd0;
    end else if (bus.enb) begin
      skp_cnt_q <= skp_cnt_d;
      skp_idx_q <= skp_idx_d;
    end
  end

  assign in_ready = bus.enb && !rst && (state_q == S_DATA) && !skp_due;
`else
  // Without SKP insertion the machine never leaves data mode.
  always_comb begin
    state_d = S_DATA;
  end

  assign in_ready = bus.enb && !rst;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DATA;
    end else if (bus.enb) begin
      state_q <= state_d;
    end
  end

  // Next output row: completed data row, or a COM/SKP row on the active lanes.
  always_comb begin
    lanes_d   = '0;
    lanes_k_d = '0;
    valid_d   = 1'b0;
    unique case (state_q)
      S_DATA: begin
        if (row_done) begin
          lanes_d   = row_data;
          lanes_k_d = row_k;
          valid_d   = 1'b1;
        end
      end
      S_COM, S_SKP: begin
        valid_d = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (i < int'(width_q)) begin
            lanes_d[8*i +: 8] = (state_q == S_COM) ? K_COM : K_SKP;
            lanes_k_d[i]      = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output row registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q   <= '0;
      lanes_k_q <= '0;
      valid_q   <= 1'b0;
    end else if (bus.enb) begin
      lanes_q   <= lanes_d;
      lanes_k_q <= lanes_k_d;
      valid_q   <= valid_d;
    end
  end

  // A held row is only presented while enabled.
  assign bus.tx_lanes       = lanes_q;
  assign bus.tx_lanes_k     = lanes_k_q;
  assign bus.tx_lanes_valid = valid_q && bus.enb;
  assign bus.in_ready       = in_ready;

endmodule

// File: tb/tb_tx_lane_striper.sv
`timescale 1ns/1ps
module tb_tx_lane_striper;
  localparam int NL = 4;
`ifdef TX_SKP_INSERT_EN
  localparam bit SKP_EN = 1'b1;
  localparam int T_INT  = 2;
  localparam int T_LEN  = 3;
`else
  localparam bit SKP_EN = 1'b0;
  localparam int T_INT  = 64;
  localparam int T_LEN  = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_lane_striper_if #(.NUM_LANES(NL)) bus ();

  tx_lane_striper #(.NUM_LANES(NL), .SKP_INTERVAL(T_INT), .SKP_LEN(T_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes of the open row, width chosen at its first byte,
  // data rows since the last ordered set, and ordered-set rows still owed.
  byte unsigned row_b[$];
  bit           row_kq[$];
  int           row_w = 1;
  int           cnt = 0;
  int           skp_left = 0;
  bit           pend_v = 1'b0;
  logic [31:0]  pend_l = '0;
  logic [3:0]   pend_k = '0;

  function automatic int width_of(input logic [1:0] c);
    int w;
    w = 1 << c;
    return (w > NL) ? NL : w;
  endfunction

  function automatic bit exp_ready();
    return bus.enb && !rst && (skp_left == 0) && !(SKP_EN && cnt == T_INT && row_b.size() == 0);
  endfunction

  task automatic model_step(input bit rdy);
    if (rst) begin
      row_b.delete(); row_kq.delete();
      cnt = 0; skp_left = 0; pend_v = 1'b0; pend_l = '0; pend_k = '0;
      return;
    end
    if (!bus.enb) return;
    pend_v = 1'b0; pend_l = '0; pend_k = '0;
    if (skp_left > 0) begin
      for (int i = 0; i < row_w; i++) begin
        pend_l[8*i +: 8] = (skp_left == T_LEN + 1) ? 8'hBC : 8'h1C;
        pend_k[i] = 1'b1;
      end
      pend_v = 1'b1;
      skp_left--;
      if (skp_left == 0) cnt = 0;
    end else if (rdy && bus.in_valid) begin
      if (row_b.size() == 0) row_w = width_of(bus.cfg_lanes);
      row_b.push_back(bus.in_data);
      row_kq.push_back(bus.in_k);
      if (row_b.size() == row_w || bus.in_last) begin
        for (int i = 0; i < NL; i++) begin
          if (i < row_b.size()) begin
            pend_l[8*i +: 8] = row_b[i]; pend_k[i] = row_kq[i];
          end else if (i < row_w) begin
            pend_l[8*i +: 8] = 8'hF7; pend_k[i] = 1'b1;
          end
        end
        pend_v = 1'b1;
        row_b.delete(); row_kq.delete();
        if (SKP_EN) begin
          if (cnt < T_INT) cnt++;
          if (cnt == T_INT) skp_left = T_LEN + 1;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit k, input bit last);
    bus.in_valid = v; bus.in_data = d; bus.in_k = k; bus.in_last = last;
  endtask

  task automatic tick(input bit rdy);
    @(posedge clk);
    model_step(rdy);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.enb = 1'b1; bus.cfg_lanes = 2'd2; drive(1'b1, 8'h5A, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_ready0 got %b want 0", bus.in_ready); else n_pass++;
    tick(1'b0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.tx_lanes_valid !== 1'b0 || bus.tx_lanes !== 32'h0 || bus.tx_lanes_k !== 4'h0)
      $display("FAIL reset_outputs got rdy=%b v=%b %h/%b want 0 0 00000000/0000",
               bus.in_ready, bus.tx_lanes_valid, bus.tx_lanes, bus.tx_lanes_k);
    else n_pass++;
    tick(1'b0);
    rst = 1'b0; drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.tx_lanes_valid !== 1'b0 || bus.tx_lanes !== 32'h0)
      $display("FAIL reset_release got rdy=%b v=%b lanes=%h want 1 0 00000000",
               bus.in_ready, bus.tx_lanes_valid, bus.tx_lanes);
    else n_pass++;
    $display("reset: released");
    tick(exp_ready());
  endtask

  task automatic test_back_to_back();
    logic [31:0] rows[$];
    int          i = 0;
    bus.cfg_lanes = 2'd2;
    for (int c = 0; c < 20; c++) begin
      bit rdy;
      if (i < 8) drive(1'b1, 8'(i + 1), 1'b0, 1'b0); else drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      rdy = exp_ready();
      n_checks++;
      if (bus.in_ready !== rdy) $display("FAIL b2b_ready got %b want %b", bus.in_ready, rdy); else n_pass++;
      n_checks++;
      if (bus.tx_lanes_valid !== pend_v || (pend_v && (bus.tx_lanes !== pend_l || bus.tx_lanes_k !== pend_k)))
        $display("FAIL b2b_row got v=%b %h/%b want v=%b %h/%b", bus.tx_lanes_valid, bus.tx_lanes, bus.tx_lanes_k, pend_v, pend_l, pend_k);
      else n_pass++;
      if (bus.tx_lanes_valid === 1'b1) begin
        rows.push_back(bus.tx_lanes);
        $display("b2b: row %h k=%b", bus.tx_lanes, bus.tx_lanes_k);
      end
      tick(rdy);
      if (rdy && i < 8) i++;
    end
    n_checks++;
    if (rows.size() < 2 || rows[0] !== 32'h04030201 || rows[1] !== 32'h08070605)
      $display("FAIL b2b_contents got %0d rows first=%h want 04030201 then 08070605",
               rows.size(), (rows.size() > 0) ? rows[0] : 32'h0);
    else n_pass++;
  endtask

  task automatic test_pad_on_last();
    logic [31:0] rows[$];
    logic [3:0]  ks[$];
    logic [7:0]  dat[2];
    int          i = 0;
    dat[0] = 8'hAA; dat[1] = 8'hBB;
    bus.cfg_lanes = 2'd2;
    for (int c = 0; c < 10; c++) begin
      bit rdy;
      if (i < 2) drive(1'b1, dat[i], 1'b0, i == 1); else drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      rdy = exp_ready();
      n_checks++;
      if (bus.in_ready !== rdy) $display("FAIL pad_ready got %b want %b", bus.in_ready, rdy); else n_pass++;
      n_checks++;
      if (bus.tx_lanes_valid !== pend_v || (pend_v && (bus.tx_lanes !== pend_l || bus.tx_lanes_k !== pend_k)))
        $display("FAIL pad_row got v=%b %h/%b want v=%b %h/%b", bus.tx_lanes_valid, bus.tx_lanes, bus.tx_lanes_k, pend_v, pend_l, pend_k);
      else n_pass++;
      if (bus.tx_lanes_valid === 1'b1) begin
        rows.push_back(bus.tx_lanes); ks.push_back(bus.tx_lanes_k);
        $display("pad: row %h k=%b", bus.tx_lanes, bus.tx_lanes_k);
      end
      tick(rdy);
      if (rdy && i < 2) i++;
    end
    n_checks++;
    if (rows.size() < 1 || rows[0] !== 32'hF7F7BBAA || ks[0] !== 4'b1100)
      $display("FAIL pad_contents got %0d rows first=%h want F7F7BBAA k=1100",
               rows.size(), (rows.size() > 0) ? rows[0] : 32'h0);
    else n_pass++;
  endtask

  task automatic test_width_change();
    logic [31:0] rows[$];
    logic [3:0]  ks[$];
    logic [7:0]  dat[6];
    logic [1:0]  cfg[6];
    int          i = 0;
    dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cfg = '{2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    for (int c = 0; c < 16; c++) begin
      bit rdy;
      if (i < 6) begin
        bus.cfg_lanes = cfg[i]; drive(1'b1, dat[i], 1'b0, 1'b0);
      end else drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      rdy = exp_ready();
      n_checks++;
      if (bus.in_ready !== rdy) $display("FAIL width_ready got %b want %b", bus.in_ready, rdy); else n_pass++;
      n_checks++;
      if (bus.tx_lanes_valid !== pend_v || (pend_v && (bus.tx_lanes !== pend_l || bus.tx_lanes_k !== pend_k)))
        $display("FAIL width_row got v=%b %h/%b want v=%b %h/%b", bus.tx_lanes_valid, bus.tx_lanes, bus.tx_lanes_k, pend_v, pend_l, pend_k);
      else n_pass++;
      if (bus.tx_lanes_valid === 1'b1 && bus.tx_lanes_k === 4'b0000) begin
        rows.push_back(bus.tx_lanes); ks.push_back(bus.tx_lanes_k);
        $display("width: row %h k=%b", bus.tx_lanes, bus.tx_lanes_k);
      end
      tick(rdy);
      if (rdy && i < 6) i++;
    end
    n_checks++;
    if (rows.size() < 2 || rows[0] !== 32'h44332211 || rows[1] !== 32'h00006655)
      $display("FAIL width_contents got %0d rows first=%h want 44332211 then 00006655",
               rows.size(), (rows.size() > 0) ? rows[0] : 32'h0);
    else n_pass++;
    bus.cfg_lanes = 2'd2;
  endtask

`ifdef TX_SKP_INSERT_EN
  task automatic test_skp_insert();
    int n_com = 0;
    int streak = 0;
    int max_streak = 0;
    bus.cfg_lanes = 2'd2;
    for (int c = 0; c < 24; c++) begin
      bit rdy;
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      #1;
      rdy = exp_ready();
      n_checks++;
      if (bus.in_ready !== rdy) $display("FAIL skp_ready got %b want %b", bus.in_ready, rdy); else n_pass++;
      n_checks++;
      if (bus.tx_lanes_valid !== pend_v || (pend_v && (bus.tx_lanes !== pend_l || bus.tx_lanes_k !== pend_k)))
        $display("FAIL skp_row got v=%b %h/%b want v=%b %h/%b", bus.tx_lanes_valid, bus.tx_lanes, bus.tx_lanes_k, pend_v, pend_l, pend_k);
      else n_pass++;
      if (bus.in_ready === 1'b0) streak++; else streak = 0;
      if (streak > max_streak) max_streak = streak;
      if (bus.tx_lanes_valid === 1'b1) begin
        if (bus.tx_lanes === 32'hBCBCBCBC) n_com++;
        $display("skp: row %h k=%b", bus.tx_lanes, bus.tx_lanes_k);
      end
      tick(rdy);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (n_com == 0 || max_streak != T_LEN + 1)
      $display("FAIL skp_sequence got com_rows=%0d ready_low_run=%0d want >0 and %0d", n_com, max_streak, T_LEN + 1);
    else n_pass++;
  endtask
`endif

  task automatic test_enb_and_reset();
    int i = 0;
    int k = 0;
    bit reset_done = 1'b0;
    bus.cfg_lanes = 2'd2;
    for (int c = 0; c < 50; c++) begin
      bit rdy;
      bus.enb = !(c >= 2 && c < 5);
      rst = 1'b0;
      if (!reset_done && c >= 8 && ((SKP_EN && skp_left == 2) || (!SKP_EN && row_b.size() == 2))) begin
        rst = 1'b1; reset_done = 1'b1; k = c;
      end
      if (!reset_done || rst) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      else drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      rdy = exp_ready();
      n_checks++;
      if (bus.in_ready !== rdy) $display("FAIL enb_ready cycle %0d got %b want %b", c, bus.in_ready, rdy); else n_pass++;
      n_checks++;
      if (bus.tx_lanes_valid !== (pend_v & bus.enb) || (pend_v && bus.enb && (bus.tx_lanes !== pend_l || bus.tx_lanes_k !== pend_k)))
        $display("FAIL enb_row cycle %0d got v=%b %h/%b want v=%b %h/%b", c, bus.tx_lanes_valid, bus.tx_lanes, bus.tx_lanes_k, pend_v & bus.enb, pend_l, pend_k);
      else n_pass++;
      if (reset_done && !rst && c > k) begin
        n_checks++;
        if (bus.tx_lanes_valid !== 1'b0) $display("FAIL post_reset_quiet cycle %0d got v=%b want 0", c, bus.tx_lanes_valid); else n_pass++;
      end
      if (bus.tx_lanes_valid === 1'b1) $display("enb: row %h k=%b", bus.tx_lanes, bus.tx_lanes_k);
      tick(rdy);
      if (rdy && bus.in_valid) i++;
      if (reset_done && c > k + 6) break;
    end
    rst = 1'b0; bus.enb = 1'b1;
    n_checks++;
    if (!reset_done) $display("FAIL enb_reset_point got none want reset mid-row/ordered-set"); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit rdy;
      bus.enb = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) bus.cfg_lanes = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      #1;
      rdy = exp_ready();
      n_checks++;
      if (bus.in_ready !== rdy) $display("FAIL rand_ready cycle %0d got %b want %b", c, bus.in_ready, rdy); else n_pass++;
      n_checks++;
      if (bus.tx_lanes_valid !== (pend_v & bus.enb) || (pend_v && bus.enb && (bus.tx_lanes !== pend_l || bus.tx_lanes_k !== pend_k)))
        $display("FAIL rand_row cycle %0d got v=%b %h/%b want v=%b %h/%b", c, bus.tx_lanes_valid, bus.tx_lanes, bus.tx_lanes_k, pend_v & bus.enb, pend_l, pend_k);
      else n_pass++;
      if (bus.tx_lanes_valid === 1'b1) $display("rand: row %h k=%b", bus.tx_lanes, bus.tx_lanes_k);
      tick(rdy);
    end
    rst = 1'b0; bus.enb = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.enb = 1'b1; bus.cfg_lanes = 2'd2;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_pad_on_last();
    test_width_change();
`ifdef TX_SKP_INSERT_EN
    test_skp_insert();
`endif
    test_enb_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
